// File: rtl/johnson_phase_decoder.sv
// Decodes a Johnson ring code into a one-hot phase and an index, tracks lock to the ring, and counts wraps/errors.
// Optional build macro JPD_STRICT_STEP_EN: a repeated code (HOLD) is treated as a sequence violation.
module johnson_phase_decoder #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              jc_in,
  input  logic                          clr_err,
  output logic [2*WIDTH-1:0]            phase,
  output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
  output logic                          valid,
  output logic                          locked,
  output logic                          wrap,
  output logic                          step_err,
  output logic [CNT_W-1:0]              cycle_cnt,
  output logic [CNT_W-1:0]              err_cnt
);
  localparam int NPH   = 2*WIDTH;
  localparam int IDX_W = $clog2(NPH);
  localparam int SC_W  = 4;
`ifdef JPD_STRICT_STEP_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef enum logic [1:0] {SEARCH, LOCKING, LOCKED} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] prev_idx, prev_n, idx, adv_idx;
  logic [SC_W-1:0]  step_cnt, step_n;
  logic [WIDTH-1:0] lo_mask, hi_mask;
  logic [NPH-1:0]   phase_n;
  logic             legal, is_adv, is_hold, is_bad, wrap_n, err_n;
  int               pc;

  // A legal code is a thermometer anchored at the LSB (MSB=0) or at the MSB (MSB=1).
  always_comb begin
    pc      = 0;
    lo_mask = '0;
    hi_mask = '0;
    for (int i = 0; i < WIDTH; i++) if (jc_in[i]) pc++;
    for (int i = 0; i < WIDTH; i++) begin
      lo_mask[i] = (i < pc);
      hi_mask[i] = (i >= WIDTH - pc);
    end
    legal = jc_in[WIDTH-1] ? (jc_in == hi_mask) : (jc_in == lo_mask);
    idx   = '0;
    if (legal) idx = jc_in[WIDTH-1] ? IDX_W'(NPH - pc) : IDX_W'(pc);
    phase_n = '0;
    if (legal) phase_n[idx] = 1'b1;
  end

  assign adv_idx = (prev_idx == IDX_W'(NPH-1)) ? '0 : prev_idx + IDX_W'(1);
  assign is_adv  = legal && (idx == adv_idx);
  assign is_hold = legal && (idx == prev_idx) && !STRICT;
  assign is_bad  = legal && !is_adv && !is_hold;

  always_comb begin
    state_n = state;
    prev_n  = prev_idx;
    step_n  = step_cnt;
    wrap_n  = 1'b0;
    err_n   = 1'b0;
    if (legal) prev_n = idx;
    case (state)
      SEARCH: begin
        if (legal) begin
          step_n  = '0;
          state_n = LOCKING;
        end
      end
      LOCKING: begin
        if (!legal) state_n = SEARCH;
        else if (is_adv) begin
          step_n = step_cnt + SC_W'(1);
          if (step_n == SC_W'(LOCK_N)) state_n = LOCKED;
        end else if (is_bad) step_n = '0;
      end
      LOCKED: begin
        if (!legal) begin
          err_n   = 1'b1;
          state_n = SEARCH;
        end else if (is_adv) wrap_n = (prev_idx == IDX_W'(NPH-1));
        else if (is_bad) begin
          err_n   = 1'b1;
          step_n  = '0;
          state_n = LOCKING;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      prev_idx <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_n;
      prev_idx <= prev_n;
      step_cnt <= step_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= '0;
      phase_idx <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      step_err  <= 1'b0;
      cycle_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      phase     <= phase_n;
      phase_idx <= idx;
      valid     <= legal;
      wrap      <= wrap_n;
      step_err  <= err_n;
      if (wrap_n && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
      // A clear coinciding with a new error leaves exactly that error counted.
      if (clr_err) err_cnt <= err_n ? CNT_W'(1) : '0;
      else if (err_n && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign locked = (state == LOCKED);
endmodule

// File: doc/johnson_phase_decoder.md
# johnson_phase_decoder

Downstream consumer of the 4-bit `johnson_counter` output. It decodes each Johnson code into a one-hot phase and an index, and checks that the sequence advances legally. A lock state machine tracks sync with the counter, and the block counts completed rings and sequence errors. It sits directly after `johnson_counter` on the same `clk`, driving phase-select logic and a status/debug interface.

## Interface
- `WIDTH`, default 4: Johnson code width; ring has 2*WIDTH states.
- `LOCK_N`, default 2: consecutive legal +1 steps required to reach LOCKED (1..15).
- `CNT_W`, default 8: width of `cycle_cnt` and `err_cnt`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `jc_in` in WIDTH: Johnson code from `johnson_counter.out`, synchronous to `clk`.
- `clr_err` in 1: synchronous clear of `err_cnt`.
- `phase` out 2*WIDTH: one-hot decoded phase; all zero when not `valid`.
- `phase_idx` out clog2(2*WIDTH): decoded index 0..2*WIDTH-1.
- `valid` out 1: last sampled code was legal.
- `locked` out 1: FSM is in LOCKED.
- `wrap` out 1: one-cycle pulse on a LOCKED step from index 2*WIDTH-1 to 0.
- `step_err` out 1: one-cycle pulse on a LOCKED sequence violation.
- `cycle_cnt` out CNT_W: saturating count of `wrap` pulses.
- `err_cnt` out CNT_W: saturating count of `step_err` pulses.

## Operation
- **Ring order.** The ring follows `out <= {out[W-2:0], ~out[W-1]}`. For WIDTH=4 it is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, giving indices 0..7.
- **Legal codes.**
  - MSB=0: the ones are contiguous from the LSB; index = popcount.
  - MSB=1: the ones are contiguous from the MSB; index = 2*WIDTH − popcount.
  - Any other code is illegal.
- **Step classes.** Each sample is compared with the stored previous index `prev_idx`:
  - ADV: next index = (prev+1) mod 2*WIDTH.
  - HOLD: same index.
  - BAD: any other legal index.
  - ILL: illegal code.
- **FSM states:** SEARCH (reset state), LOCKING, LOCKED.
- **SEARCH:**
  - Legal code: load `prev_idx`, clear the step count, go to LOCKING.
  - Illegal code: stay in SEARCH.
- **LOCKING:**
  - ADV: increment the step count. When it reaches LOCK_N, go to LOCKED.
  - HOLD: no change.
  - BAD: reload `prev_idx`, reset the step count to 0, stay in LOCKING.
  - ILL: go to SEARCH.
  - No error is reported in this state.
- **LOCKED:**
  - ADV: stay in LOCKED. Pulse `wrap` on the transition from 2*WIDTH−1 to 0.
  - HOLD: allowed; no pulse.
  - BAD: pulse `step_err`, reload `prev_idx`, go to LOCKING.
  - ILL: pulse `step_err`, go to SEARCH.
- **`prev_idx` update.** Updated on every legal sample; kept unchanged on an illegal sample.
- **Counters.**
  - `cycle_cnt` increments on `wrap` and saturates at 2^CNT_W−1. It is not cleared by `clr_err`.
  - `err_cnt` increments on `step_err` and saturates.
  - `clr_err` together with `step_err` in the same cycle gives `err_cnt` = 1.

## Timing
- **Output latency.** All outputs are registered. `jc_in` sampled at edge k appears on `phase`, `phase_idx`, `valid`, `wrap` and `step_err` after edge k (latency 1).
- **`locked` timing.** `locked` rises after the edge that samples the LOCK_N-th ADV. `locked` falls after the edge that samples the violating code.
- **Pulse width.** `wrap` and `step_err` are high for exactly one cycle per event.
- **Lock-up time.** A clean ring locks after LOCK_N+1 samples (one to acquire, then LOCK_N ADVs).
- **Reset.**
  - Reset is asynchronous: `reset`=0 immediately forces every output to 0, the FSM to SEARCH, and `prev_idx` and the step count to 0.
  - Release is sampled at the next rising edge.
- **Reset mid-operation** discards lock; re-acquisition starts from SEARCH.
- **Input stalls.** A counter held in its own reset (0000 repeated) is HOLD and produces no error.

## Configuration
- `JPD_STRICT_STEP_EN`:
  - **Defined:** HOLD is treated as BAD in both LOCKING and LOCKED, for a counter that must advance every cycle. In LOCKED a HOLD pulses `step_err` and returns the FSM to LOCKING.
  - **Undefined:** HOLD is accepted silently, as described above.

## Test plan
- **Clean ring:** hold `reset`=0 for 20 ns, release, drive the ring 0000→0001→…→1000→0000 once per clock.
  - `locked`=1 after the third sample.
  - `phase_idx` follows 0..7 one cycle late.
  - `wrap` pulses once per 8 cycles.
  - `cycle_cnt`=3 after 3 full rings.
- **Illegal code:** while LOCKED, inject 0101 for one cycle.
  - `valid`=0, `phase`=0, `step_err` pulse, `locked`=0, `err_cnt`=1.
  - Relock after 3 clean samples.
- **Skipped state:** while LOCKED, jump 0011→1111 (index 2→4).
  - `step_err` pulse, `err_cnt`+1, FSM in LOCKING with `prev_idx`=4.
  - Next ADVs 4→5→6 give `locked`=1.
- **Hold:** while LOCKED, repeat 0111 for 5 cycles.
  - Default: no error and `locked` stays 1.
  - With `JPD_STRICT_STEP_EN`: `step_err` on the first repeat and `locked`=0.
- **Simultaneous clear and error:** assert `clr_err` in the same cycle as a `step_err` with `err_cnt`=5 → `err_cnt`=1.
- **Async reset and saturation:**
  - Assert `reset`=0 mid-cycle while LOCKED: all outputs go to 0 before the next edge.
  - With CNT_W=2, 5 errors leave `err_cnt`=3.
